// File: rtl/led_pio_pkg.sv
// Shared register-map constants for the LED PIO with blink and PWM.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_BRIGHT   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned MaxPwmBits = 16;

  // BRIGHT resets to full brightness; the top slices this to PWM_BITS.
  localparam logic [MaxPwmBits-1:0] BRIGHT_RST_MAX = '1;

endpackage

// File: rtl/led_blink_timer.sv
// Blink half-period timer: toggles phase_o every `period_i` cycles, idles high when period is 0.
module led_blink_timer #(
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [BLINK_BITS-1:0] period_i,
  input  logic                  period_wr_i,
  output logic                  phase_o
);

  logic [BLINK_BITS-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [BLINK_BITS-1:0] period_m1;

  assign period_m1 = period_i - 1'b1;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (period_wr_i || (period_i == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_m1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    // A count already past a lowered period simply wraps through max.
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM LED port with atomic set/clear, per-bit blink and global PWM brightness.
module led_pio_pwm
  import led_pio_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PWM_BITS-1:0] BrightRst = BRIGHT_RST_MAX[PWM_BITS-1:0];

  logic                  wr;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [BLINK_BITS-1:0] period_q, period_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic                  period_wr;
  logic                  blink_phase;
  logic                  pwm_on;
  logic                  unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    data_d    = data_q;
    mode_d    = mode_q;
    period_d  = period_q;
    bright_d  = bright_q;
    period_wr = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d = writedata[WIDTH-1:0];
        ADDR_MODE:     mode_d = writedata[WIDTH-1:0];
        ADDR_PERIOD: begin
          period_d  = writedata[BLINK_BITS-1:0];
          period_wr = 1'b1;
        end
        ADDR_BRIGHT:   bright_d = writedata[PWM_BITS-1:0];
        ADDR_OUTSET:   data_d = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_d = data_q & ~writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  led_blink_timer #(
    .BLINK_BITS (BLINK_BITS)
  ) u_blink_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .period_i    (period_q),
    .period_wr_i (period_wr),
    .phase_o     (blink_phase)
  );

  // Full-scale BRIGHT forces on so 100% has no gap at pwm_cnt wrap.
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign pwm_on    = (bright_q == BrightRst) | (pwm_cnt_q < bright_q);

  assign out_d = data_q & (~mode_q | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      mode_q    <= '0;
      period_q  <= '0;
      bright_q  <= BrightRst;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      data_q    <= data_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      bright_q  <= bright_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]      = data_q;
      ADDR_MODE:   readdata[WIDTH-1:0]      = mode_q;
      ADDR_PERIOD: readdata[BLINK_BITS-1:0] = period_q;
      ADDR_BRIGHT: readdata[PWM_BITS-1:0]   = bright_q;
      default:     ;
    endcase
  end

endmodule

// File: doc/led_pio_pwm.md
Name: led_pio_pwm

Overview:
- Parametrised successor to the board LED output port: Avalon-MM slave driving WIDTH LED outputs.
- Adds atomic bit set/clear, per-bit blink mode with a programmable period, and global PWM brightness.
- Sits on the processor's peripheral bus in place of the plain LED PIO; `out_port` goes straight to the LED pins.

Parameters:
- WIDTH, 10, number of LED outputs (1..32).
- PWM_BITS, 8, PWM counter/brightness width (1..16).
- BLINK_BITS, 24, blink half-period counter width (1..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data (combinational, zero wait states, read latency 0).
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Write: `wr = chipselect & ~write_n`. All state updates on `posedge clk`.
- Register map (unused high bits read 0 and are ignored on write):
  - 0 DATA (rw, WIDTH).
  - 1 MODE (rw, WIDTH): bit=1 means that LED blinks.
  - 2 PERIOD (rw, BLINK_BITS): half-period in clk cycles.
  - 3 BRIGHT (rw, PWM_BITS).
  - 4 OUTSET (wo): `DATA |= writedata`.
  - 5 OUTCLEAR (wo): `DATA &= ~writedata`.
  - 4..7 read 0. Writes to 6 and 7 are ignored.
- Reset values:
  - DATA, MODE, PERIOD = 0.
  - BRIGHT = all ones.
  - pwm_cnt, blink_cnt = 0; blink_phase = 1.
  - out_port = 0.
- Reset has priority over any simultaneous write. Reset mid-blink or mid-PWM returns all state to reset values in the next cycle.
- PWM:
  - pwm_cnt free-runs 0 .. 2^PWM_BITS-1 and wraps to 0.
  - `pwm_on = (BRIGHT == all ones) | (pwm_cnt < BRIGHT)`.
  - BRIGHT=0 gives LEDs fully off. All ones gives 100% on (no one-cycle gap).
- Blink:
  - If PERIOD == 0: blink_cnt held at 0, blink_phase held at 1.
  - Else blink_cnt increments each cycle. When `blink_cnt == PERIOD-1`: blink_cnt <= 0 and blink_phase toggles.
  - A write to PERIOD clears blink_cnt to 0 and sets blink_phase to 1 in the same edge.
  - If PERIOD is lowered below the current count, the counter wraps at max and continues. This is not reachable when the write itself clears the counter.
- Output (registered): `out_port[i] <= DATA[i] & (MODE[i] ? blink_phase : 1) & pwm_on`.
  - Latency: a write at edge N is visible on `out_port` after edge N+1.
- Reads reflect register state combinationally, including a write committed on the prior edge.
- OUTSET/OUTCLEAR with writedata=0 leave DATA unchanged.

Decomposition:
- Shared package `led_pio_pkg`:
  - Address constants ADDR_DATA=0, ADDR_MODE=1, ADDR_PERIOD=2, ADDR_BRIGHT=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - Reset constant for BRIGHT.
- One natural sub-module, `led_blink_timer` (BLINK_BITS): period in, period_wr in, phase out. The PWM counter stays inline.

Test Plan:
- Reset, then read all addresses → DATA/MODE/PERIOD read 0, BRIGHT reads 0xFF, `out_port` = 0.
- Write DATA=0x2A5, keep BRIGHT=0xFF → `out_port` = 0x2A5 from the second edge after the write; readback of DATA = 0x2A5.
- Continue from DATA=0x2A5:
  - OUTSET 0x00A → DATA reads 0x2AF.
  - Then OUTCLEAR 0x201 → DATA reads 0x0AE.
  - Write 0x3 to address 6 → no register change.
- DATA=0x3FF, MODE=0x001, PERIOD=4 → `out_port[0]` toggles every 4 cycles (4 high, 4 low, starting high); bits 9:1 stay 1. A PERIOD rewrite mid-low phase restarts the high phase.
- DATA=0x001, BRIGHT=0x40 → `out_port[0]` high for exactly 64 of every 256 cycles.
  - BRIGHT=0 → constant 0.
  - BRIGHT=0xFF → constant 1.
- Assert reset mid-blink with writes pending → next cycle `out_port` = 0 and all registers at reset values; a write in the same cycle as reset is discarded.
